// File: rtl/sipo_frame_deserializer.sv
// Serial-in parallel-out frame deserializer with a valid/ready holding register.
// Ports:
//   clk, rst (sync, active-high), clr (abort partial frame), sin/sin_valid (serial bit),
//   status/out_valid/out_ready (frame handshake), bit_cnt, overrun (sticky), parity_err.
// Optional: define SIPO_PARITY_EN for a trailing even-parity bit per frame.
module sipo_frame_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       bit_cnt,
  output logic             overrun,
  output logic             parity_err
);

`ifdef SIPO_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam logic [5:0] LAST = 6'(FL - 1);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_shift;
  logic [WIDTH-1:0] frame;
  logic             accept;
  logic             last;
  logic             free;
  logic             data_bit;

  always_comb begin
    sh_shift = '0;
    if (LSB_FIRST) sh_shift = {sin, sh[WIDTH-1:1]};
    else           sh_shift = {sh[WIDTH-2:0], sin};
  end

  assign accept = sin_valid & ~clr;
  assign last   = accept & (bit_cnt == LAST);
  // Holding register may take a new frame if empty or drained this edge.
  assign free   = ~out_valid | out_ready;

`ifdef SIPO_PARITY_EN
  logic par;

  // The trailing parity bit is never shifted into the data register,
  // so on completion sh already holds the full data word.
  assign data_bit = (bit_cnt < 6'(WIDTH));
  assign frame    = sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      par        <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (clr || last)  par <= 1'b0;
      else if (accept)  par <= par ^ sin;
      if (last && free) parity_err <= par ^ sin;
    end
  end
`else
  assign data_bit   = 1'b1;
  assign frame      = sh_shift;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sh        <= '0;
      bit_cnt   <= '0;
      status    <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (clr) begin
        sh      <= '0;
        bit_cnt <= '0;
      end else if (sin_valid) begin
        if (data_bit) sh <= sh_shift;
        bit_cnt <= last ? 6'd0 : bit_cnt + 6'd1;
      end

      if (last && free) begin
        status    <= frame;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (last && !free) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sipo_frame_deserializer.sv
// Bench for sipo_frame_deserializer: LSB-first and MSB-first instances
// share stimulus and are compared each cycle against a frame-level model.
module tb_sipo_frame_deserializer;

  localparam int W = 8;
`ifdef SIPO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic sin = 1'b0;
  logic sin_valid = 1'b0;
  logic out_ready = 1'b0;

  logic [W-1:0] status_l, status_m;
  logic         ov_l, ov_m, ovr_l, ovr_m, pe_l, pe_m;
  logic [5:0]   cnt_l, cnt_m;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sipo_frame_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .clr(clr), .sin(sin), .sin_valid(sin_valid),
    .status(status_l), .out_valid(ov_l), .out_ready(out_ready),
    .bit_cnt(cnt_l), .overrun(ovr_l), .parity_err(pe_l)
  );

  sipo_frame_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .clr(clr), .sin(sin), .sin_valid(sin_valid),
    .status(status_m), .out_valid(ov_m), .out_ready(out_ready),
    .bit_cnt(cnt_m), .overrun(ovr_m), .parity_err(pe_m)
  );

  // Frame-level model: collect bits of the current frame in order,
  // then build both bit orders arithmetically on completion.
  int           m_cnt = 0;
  logic         m_bits [FL];
  logic [W-1:0] m_stat_l = '0;
  logic [W-1:0] m_stat_m = '0;
  logic         m_valid = 1'b0;
  logic         m_over = 1'b0;
  logic         m_perr = 1'b0;

  always @(posedge clk) begin : model
    logic         done;
    logic [W-1:0] wl, wm;
    logic         p;
    done = 1'b0;
    if (rst) begin
      m_cnt = 0; m_stat_l = '0; m_stat_m = '0;
      m_valid = 1'b0; m_over = 1'b0; m_perr = 1'b0;
    end else begin
      if (clr) m_cnt = 0;
      else if (sin_valid) begin
        m_bits[m_cnt] = sin;
        if (m_cnt == FL - 1) begin
          done = 1'b1;
          m_cnt = 0;
        end else m_cnt++;
      end
      if (done) begin
        wl = '0; wm = '0; p = 1'b0;
        for (int i = 0; i < W; i++) begin
          wl[i]       = m_bits[i];
          wm[W-1-i]   = m_bits[i];
        end
        for (int i = 0; i < FL; i++) p ^= m_bits[i];
        if (!m_valid || out_ready) begin
          m_stat_l = wl;
          m_stat_m = wm;
          m_perr   = (FL > W) ? p : 1'b0;
          m_valid  = 1'b1;
        end else m_over = 1'b1;
      end else if (m_valid && out_ready) m_valid = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_status_lsb", 32'(status_l), 32'(m_stat_l));
    chk("cmp_status_msb", 32'(status_m), 32'(m_stat_m));
    chk("cmp_valid_lsb", 32'(ov_l), 32'(m_valid));
    chk("cmp_valid_msb", 32'(ov_m), 32'(m_valid));
    chk("cmp_cnt_lsb", 32'(cnt_l), 32'(m_cnt));
    chk("cmp_cnt_msb", 32'(cnt_m), 32'(m_cnt));
    chk("cmp_overrun_lsb", 32'(ovr_l), 32'(m_over));
    chk("cmp_overrun_msb", 32'(ovr_m), 32'(m_over));
    chk("cmp_perr_lsb", 32'(pe_l), 32'(m_perr));
    chk("cmp_perr_msb", 32'(pe_m), 32'(m_perr));
  end

  task automatic cyc(input logic v, input logic s, input logic r,
                     input logic c, input logic rs);
    sin_valid = v;
    sin       = s;
    out_ready = r;
    clr       = c;
    rst       = rs;
    @(negedge clk);
  endtask

  // Sends v[0] first; parity bit p follows when parity is compiled in.
  // out_ready is driven only on the completing edge.
  task automatic send(input logic [W-1:0] v, input logic p, input logic rdy);
    logic b;
    for (int i = 0; i < FL; i++) begin
      b = (i < W) ? v[i] : p;
      cyc(1'b1, b, (i == FL - 1) ? rdy : 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("rst_status", 32'(status_l), 32'h0);
    chk("rst_valid", 32'(ov_l), 32'h0);
    chk("rst_cnt", 32'(cnt_l), 32'h0);
    chk("rst_overrun", 32'(ovr_l), 32'h0);

    // 1,0,1,1,0,0,1,0 in send order
    send(8'h4D, 1'b0, 1'b0);
    chk("lsb_first_4d", 32'(status_l), 32'h4D);
    chk("msb_first_b2", 32'(status_m), 32'hB2);
    chk("frame_valid", 32'(ov_l), 32'h1);
    chk("frame_cnt0", 32'(cnt_l), 32'h0);

    send(8'hFF, 1'b0, 1'b0);
    chk("ovr_status_kept", 32'(status_l), 32'h4D);
    chk("ovr_flag", 32'(ovr_l), 32'h1);
    cyc(0, 0, 1, 0, 0);
    chk("ovr_drain_valid", 32'(ov_l), 32'h0);
    chk("ovr_sticky", 32'(ovr_l), 32'h1);

    cyc(0, 0, 0, 0, 1);
    send(8'h4D, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b1);
    chk("simul_status", 32'(status_l), 32'hFF);
    chk("simul_valid", 32'(ov_l), 32'h1);
    chk("simul_no_ovr", 32'(ovr_l), 32'h0);

    repeat (3) cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 1, 1, 0);
    chk("clr_cnt", 32'(cnt_l), 32'h0);
    send(8'h1E, 1'b0, 1'b0);
    chk("clean_lsb", 32'(status_l), 32'h1E);
    chk("clean_msb", 32'(status_m), 32'h78);
    chk("clean_ovr", 32'(ovr_l), 32'h0);

    repeat (5) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 1);
    chk("mid_rst_status", 32'(status_l), 32'h0);
    chk("mid_rst_valid", 32'(ov_l), 32'h0);
    chk("mid_rst_cnt", 32'(cnt_l), 32'h0);
    chk("mid_rst_ovr", 32'(ovr_l), 32'h0);
    chk("mid_rst_perr", 32'(pe_l), 32'h0);

`ifdef SIPO_PARITY_EN
    send(8'h4D, 1'b0, 1'b0);
    chk("par_ok_status", 32'(status_l), 32'h4D);
    chk("par_ok_err", 32'(pe_l), 32'h0);
    send(8'h4D, 1'b1, 1'b1);
    chk("par_bad_status", 32'(status_l), 32'h4D);
    chk("par_bad_err", 32'(pe_l), 32'h1);
`endif

    for (int n = 0; n < 4000; n++) begin
      cyc(1'($urandom_range(0, 9) < 7),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 9) < ((n / 500) % 2 == 0 ? 5 : 1)),
          1'($urandom_range(0, 49) == 0),
          1'($urandom_range(0, 399) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sipo_frame_deserializer.md
# sipo_frame_deserializer

Parametrised serial-in, parallel-out deserializer: the next generation of the 8-bit shift register used on the output side of the assignment datapaths. It accepts one qualified serial bit per clock. It assembles frames of WIDTH bits in a selectable bit order and presents each completed frame in a holding register with a valid/ready handshake. Serial capture continues while the consumer drains the previous frame, and a sticky flag records overruns.

## Interface
- WIDTH, 8: data bits per frame; legal range 2..32.
- LSB_FIRST, 1: 1 = first received bit lands in status[0]; 0 = first received bit lands in status[WIDTH-1].

- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous frame abort; discards the partial frame only.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled on this edge.
- status  output  WIDTH  holding register with the last completed frame.
- out_valid  output  1  status holds an unconsumed frame.
- out_ready  input  1  consumer accepts status on an edge where out_valid=1.
- bit_cnt  output  6  bits accepted into the current partial frame.
- overrun  output  1  sticky: a completed frame was dropped.
- parity_err  output  1  parity result for the frame in status (see Configuration).

## Operation
- Reset (rst=1 at an edge): shift register, status, bit_cnt, out_valid, overrun and parity_err all go to 0. rst has priority over every other input.
- clr=1 (rst=0): bit_cnt and the shift register go to 0. Holding register, out_valid and overrun are untouched. The out_ready handshake is still honoured that cycle, and sin_valid is ignored.
- Shift with LSB_FIRST=1: sh <= {sin, sh[WIDTH-1:1]}. This gives the original shift direction.
- Shift with LSB_FIRST=0: sh <= {sh[WIDTH-2:0], sin}.
- No shift and no count change when sin_valid=0.
- Frame length FL = WIDTH data bits, or WIDTH+1 when parity is compiled in.
- bit_cnt counts 0..FL-1. On the accepting edge where bit_cnt=FL-1 the frame completes and bit_cnt wraps to 0.
- Frame completion when the holding register is free (out_valid=0, or out_valid=1 with out_ready=1 on the same edge):
  - status is loaded with the fully shifted data, including the bit sampled on this edge.
  - out_valid is 1 after the edge.
- Frame completion when the holding register is busy (out_valid=1, out_ready=0):
  - The new frame is dropped; status and parity_err keep their old values.
  - overrun becomes 1 and stays 1 until rst. clr does not clear it.
- Handshake: out_valid falls on an edge with out_valid=1, out_ready=1 and no simultaneous completion. out_ready is ignored while out_valid=0.
- status is stable whenever out_valid=1 until that frame is accepted.

## Timing
- Latency: out_valid is 1 in the cycle after the edge that samples the final bit of a frame.
- Throughput: one frame per FL accepted bits. Back-to-back frames with no idle cycle are legal.
- Simultaneous completion and acceptance produces no bubble and no overrun: out_valid stays 1 and status changes.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro SIPO_PARITY_EN.
- Defined: each frame carries one extra trailing bit after the WIDTH data bits, and FL = WIDTH+1.
  - The parity bit is never stored in status.
  - parity_err is loaded together with status: 1 if the XOR of the WIDTH data bits and the parity bit is 1 (even parity violated).
  - Frames with bad parity are still delivered.
  - The parity bit counts toward bit_cnt.
- Not defined: FL = WIDTH and parity_err is constant 0. The port remains so benches and instantiations are unchanged.

## Test plan
- Bit order, LSB first: WIDTH=8, LSB_FIRST=1, send 1,0,1,1,0,0,1,0 on consecutive cycles -> status=8'h4D and out_valid=1 one cycle after the last bit; bit_cnt=0.
- Bit order, MSB first: LSB_FIRST=0 with the same stream -> status=8'hB2.
- Overrun: hold out_ready=0 and send two full frames (8'h4D, then 8'hFF) -> status stays 8'h4D and overrun=1. Then assert out_ready for one cycle -> out_valid=0, overrun still 1.
- Simultaneous completion and accept: out_ready=1 on the edge completing frame 8'hFF while 8'h4D is pending -> status=8'hFF, out_valid stays 1, overrun=0.
- Reset and abort mid-frame:
  - After 3 bits, pulse clr -> bit_cnt=0; the next 8 bits form a clean frame.
  - After 5 bits, assert rst -> every output is 0 on the next cycle.
- Parity (SIPO_PARITY_EN defined), data 1,0,1,1,0,0,1,0:
  - Parity bit 0 -> status=8'h4D, parity_err=0.
  - Parity bit 1 -> status=8'h4D, parity_err=1.
